pipe_controller: RTL and testbench
==================================

Name: pipe_controller

Overview:
- Next-generation pipelined RV32I control unit. Decodes in D and carries control through the D/E, E/M and M/W registers.
- Resolves branches and jumps in E from ALU flags and drives PCSrcE.
- Optional M-extension decode. ALUControl width is parametrised.
- Sits beside the pipelined datapath. Hazard unit supplies stall/flush.

Parameters:
- ALUCTRL_W, 5, ALUControl width (min 5).
- EN_MEXT, 1, when 1, decodes OP with funct7=0000001 as MUL/DIV; when 0, treats it as illegal.
- EN_ILLEGAL_TRAP, 1, when 1, an illegal instruction is injected as a bubble (all write enables 0).

Ports:
- clk  in  1  clock
- n_rst  in  1  synchronous reset, active-HIGH (1 = reset)
- opcode  in  7  InstrD[6:0]
- funct3  in  3  InstrD[14:12]
- funct7  in  7  InstrD[31:25]
- StallE  in  1  hold the D/E control register
- FlushE  in  1  load a bubble into D/E
- N_flag, Z_flag, C_flag, V_flag  in  1 each  E-stage ALU flags from rs1-rs2
- ImmSrcD  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- IllegalD  out  1  D-stage instruction undecodable
- ALUControlE  out  ALUCTRL_W  E-stage ALU operation
- ALUSrcAE  out  2  00 rs1, 01 PC, 10 zero
- ALUSrcBE  out  1  0 rs2, 1 imm
- PCSrcE  out  2  00 PC+4, 01 PC+imm, 10 ALU result (jalr)
- ResultSrcE0  out  1  ResultSrcE[0], for load-use detection
- MemWriteM  out  1  store enable
- RegWriteM  out  1  for forwarding
- ResultSrcW  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm
- RegWriteW  out  1  register-file write enable

Behaviour:
- **Decode (combinational in D)**
  - lw: I, RegWrite, ALUSrcB=1, ResultSrc=01.
  - sw: S, MemWrite, ALUSrcB=1.
  - R-type: RegWrite.
  - I-ALU: RegWrite, ALUSrcB=1.
  - beq..bgeu: B, Branch, ALU sub.
  - jal: J, Jump, RegWrite, ResultSrc=10.
  - jalr: I, Jump, JumpReg, ALUSrcB=1, RegWrite, ResultSrc=10.
  - lui: U, RegWrite, ResultSrc=11.
  - auipc: U, ALUSrcA=01, ALUSrcB=1, RegWrite.
- **ALUControl codes:** add 0, sub 1, and 2, or 3, xor 4, slt 5, sltu 6, sll 7, srl 8, sra 9.
  - sub is selected for R-type with funct7[5]=1 and funct3=000.
  - sra is selected when funct3=101 and funct7[5]=1 (R and I forms).
  - M-ext: 5'b10000 | funct3, zero-extended to ALUCTRL_W.
- **Illegal instructions**
  - Any unlisted opcode, or unlisted funct3/funct7 combination, asserts IllegalD.
  - If EN_ILLEGAL_TRAP, the instruction's RegWrite, MemWrite, Branch and Jump are forced to 0 before the D/E register.
  - IllegalD is a D-stage combinational output only; it is never registered.
- **D/E register**
  - n_rst, or FlushE: all control fields 0 (bubble). Flush has priority over stall.
  - Else if StallE: hold.
  - Else: load the D decode.
- **E/M and M/W registers**
  - n_rst: clear to 0.
  - Otherwise load every cycle; no stall or flush.
- **Branch evaluation in E**
  - beq Z; bne !Z; blt N^V; bge !(N^V); bltu !C; bgeu C.
  - C=1 means no borrow.
  - BtakenE = BranchE & condition(funct3E).
  - Branch with reserved funct3 (010/011): not taken.
- **PCSrcE**
  - JumpReg → 10.
  - Else if JumpE or BtakenE → 01.
  - Else → 00.
  - A bubble yields 00.
- **Latency:** D inputs appear on E outputs 1 cycle later, on M outputs 2 cycles later, on W outputs 3 cycles later.
- **Reset values:** every registered output is 0 while n_rst=1 and on the first cycle after it deasserts. Reset mid-stream discards all in-flight control.

Test Plan:
- Reset: hold n_rst=1 for 2 cycles with opcode=0110011 → all E/M/W outputs 0. Release → ALUControlE=0 one cycle later.
- add/sub: issue R-type funct7=0000000 then 0100000 (funct3=000) → ALUControlE=0 then 1. RegWriteW=1 three cycles after each.
- beq with Z=1 → PCSrcE=01. Same beq with Z=0 → PCSrcE=00. bltu with C=0 → 01. bgeu with C=0 → 00.
- jalr (1100111): PCSrcE=10, ResultSrcW=10, RegWriteW=1 at +3 cycles.
- Stall/flush: lw in D/E with StallE=1 for 2 cycles → ResultSrcE0 held at 1. Then assert FlushE and StallE together → next cycle all E outputs 0; MemWriteM=0 and RegWriteM=0 one cycle later.
- Illegal: opcode=1111111 → IllegalD=1 in the same cycle. RegWriteW=0 and MemWriteM=0 downstream. With EN_MEXT=1, funct7=0000001 and funct3=100 → ALUControlE=5'b10100.

Source files
------------

// File: rtl/pipe_controller.sv
// Pipelined RV32I control unit: decodes in D and carries control through the D/E, E/M and M/W registers.
// Branches and jumps are resolved in E from the ALU flags.
module pipe_controller #(
  parameter int unsigned ALUCTRL_W       = 5,
  parameter bit          EN_MEXT         = 1'b1,
  parameter bit          EN_ILLEGAL_TRAP = 1'b1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 N_flag,
  input  logic                 Z_flag,
  input  logic                 C_flag,
  input  logic                 V_flag,
  output logic [2:0]           ImmSrcD,
  output logic                 IllegalD,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic [1:0]           ALUSrcAE,
  output logic                 ALUSrcBE,
  output logic [1:0]           PCSrcE,
  output logic                 ResultSrcE0,
  output logic                 MemWriteM,
  output logic                 RegWriteM,
  output logic [1:0]           ResultSrcW,
  output logic                 RegWriteW
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam int unsigned DE_W = ALUCTRL_W + 13;
  localparam int unsigned EM_W = 4;
  localparam int unsigned MW_W = 3;

  // Base ALU operation shared by the R and I forms.
  function automatic logic [4:0] alu_of_funct3(input logic [2:0] f3);
    case (f3)
      3'b000:  return 5'd0;
      3'b001:  return 5'd7;
      3'b010:  return 5'd5;
      3'b011:  return 5'd6;
      3'b100:  return 5'd4;
      3'b101:  return 5'd8;
      3'b110:  return 5'd3;
      default: return 5'd2;
    endcase
  endfunction

  logic                 dec_reg_write, dec_mem_write, dec_jump, dec_jump_reg, dec_branch;
  logic                 dec_alu_src_b;
  logic [1:0]           dec_result_src, dec_alu_src_a;
  logic [4:0]           dec_alu_ctrl;
  logic [ALUCTRL_W-1:0] dec_alu_ctrl_w;
  logic                 kill_d;

  always_comb begin
    dec_reg_write  = 1'b0;
    dec_mem_write  = 1'b0;
    dec_jump       = 1'b0;
    dec_jump_reg   = 1'b0;
    dec_branch     = 1'b0;
    dec_alu_src_b  = 1'b0;
    dec_result_src = 2'b00;
    dec_alu_src_a  = 2'b00;
    dec_alu_ctrl   = 5'd0;
    ImmSrcD        = 3'b000;
    IllegalD       = 1'b0;
    case (opcode)
      OP_LOAD: begin
        dec_reg_write  = 1'b1;
        dec_alu_src_b  = 1'b1;
        dec_result_src = 2'b01;
        IllegalD       = (funct3 != 3'b010);
      end
      OP_STORE: begin
        ImmSrcD       = 3'b001;
        dec_mem_write = 1'b1;
        dec_alu_src_b = 1'b1;
        IllegalD      = (funct3 != 3'b010);
      end
      OP_R: begin
        dec_reg_write = 1'b1;
        if (funct7 == F7_BASE)                         dec_alu_ctrl = alu_of_funct3(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000) dec_alu_ctrl = 5'd1;
        else if (funct7 == F7_ALT && funct3 == 3'b101) dec_alu_ctrl = 5'd9;
        else if (funct7 == F7_MEXT && EN_MEXT)         dec_alu_ctrl = {2'b10, funct3};
        else                                           IllegalD     = 1'b1;
      end
      OP_I: begin
        dec_reg_write = 1'b1;
        dec_alu_src_b = 1'b1;
        dec_alu_ctrl  = alu_of_funct3(funct3);
        // Only the shift immediates constrain funct7.
        if (funct3 == 3'b001) begin
          IllegalD = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) dec_alu_ctrl = 5'd9;
          else                  IllegalD     = (funct7 != F7_BASE);
        end
      end
      OP_BRANCH: begin
        ImmSrcD      = 3'b010;
        dec_branch   = 1'b1;
        dec_alu_ctrl = 5'd1;
        IllegalD     = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        ImmSrcD        = 3'b100;
        dec_jump       = 1'b1;
        dec_reg_write  = 1'b1;
        dec_result_src = 2'b10;
      end
      OP_JALR: begin
        dec_jump       = 1'b1;
        dec_jump_reg   = 1'b1;
        dec_alu_src_b  = 1'b1;
        dec_reg_write  = 1'b1;
        dec_result_src = 2'b10;
        IllegalD       = (funct3 != 3'b000);
      end
      OP_LUI: begin
        ImmSrcD        = 3'b011;
        dec_reg_write  = 1'b1;
        dec_result_src = 2'b11;
      end
      OP_AUIPC: begin
        ImmSrcD       = 3'b011;
        dec_alu_src_a = 2'b01;
        dec_alu_src_b = 1'b1;
        dec_reg_write = 1'b1;
      end
      default: IllegalD = 1'b1;
    endcase
  end

  assign dec_alu_ctrl_w = ALUCTRL_W'(dec_alu_ctrl);
  assign kill_d         = EN_ILLEGAL_TRAP && IllegalD;

  logic [DE_W-1:0] de_d, de_q;
  logic [EM_W-1:0] em_d, em_q;
  logic [MW_W-1:0] mw_d, mw_q;

  logic       reg_write_e, mem_write_e, jump_e, jump_reg_e, branch_e;
  logic [1:0] result_src_e, result_src_m;
  logic [2:0] funct3_e;
  logic       cond_e, btaken_e;

  assign {reg_write_e, result_src_e, mem_write_e, jump_e, jump_reg_e, branch_e,
          ALUControlE, ALUSrcAE, ALUSrcBE, funct3_e} = de_q;
  assign {RegWriteM, MemWriteM, result_src_m} = em_q;
  assign {RegWriteW, ResultSrcW}              = mw_q;
  assign ResultSrcE0                          = result_src_e[0];

  // Pipeline next-state: flush beats stall; illegal instructions enter as bubbles.
  always_comb begin
    de_d = de_q;
    if (FlushE) begin
      de_d = '0;
    end else if (!StallE) begin
      de_d = kill_d ? '0 : {dec_reg_write, dec_result_src, dec_mem_write, dec_jump, dec_jump_reg,
                            dec_branch, dec_alu_ctrl_w, dec_alu_src_a, dec_alu_src_b, funct3};
    end
    em_d = {reg_write_e, mem_write_e, result_src_e};
    mw_d = {RegWriteM, result_src_m};
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      de_q <= '0;
      em_q <= '0;
      mw_q <= '0;
    end else begin
      de_q <= de_d;
      em_q <= em_d;
      mw_q <= mw_d;
    end
  end

  // Branch condition from the rs1-rs2 flags; C=1 means no borrow.
  always_comb begin
    cond_e = 1'b0;
    case (funct3_e)
      3'b000:  cond_e = Z_flag;
      3'b001:  cond_e = !Z_flag;
      3'b100:  cond_e = N_flag ^ V_flag;
      3'b101:  cond_e = !(N_flag ^ V_flag);
      3'b110:  cond_e = !C_flag;
      3'b111:  cond_e = C_flag;
      default: cond_e = 1'b0;
    endcase
  end

  assign btaken_e = branch_e & cond_e;

  always_comb begin
    PCSrcE = 2'b00;
    if (jump_reg_e)                PCSrcE = 2'b10;
    else if (jump_e || btaken_e)   PCSrcE = 2'b01;
  end

endmodule

// File: tb/tb_pipe_controller.sv
// Self-checking bench for pipe_controller: directed steps, then randomized traffic against a
// reference model that tracks each instruction's control through E, M and W.
module tb_pipe_controller;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       StallE, FlushE;
  logic       N_flag, Z_flag, C_flag, V_flag;
  logic [2:0] ImmSrcD;
  logic       IllegalD;
  logic [4:0] ALUControlE;
  logic [1:0] ALUSrcAE;
  logic       ALUSrcBE;
  logic [1:0] PCSrcE;
  logic       ResultSrcE0;
  logic       MemWriteM, RegWriteM;
  logic [1:0] ResultSrcW;
  logic       RegWriteW;

  always #5 clk = ~clk;

  pipe_controller #(.ALUCTRL_W(5), .EN_MEXT(1'b1), .EN_ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .StallE(StallE), .FlushE(FlushE),
    .N_flag(N_flag), .Z_flag(Z_flag), .C_flag(C_flag), .V_flag(V_flag),
    .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .ALUControlE(ALUControlE),
    .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .PCSrcE(PCSrcE), .ResultSrcE0(ResultSrcE0),
    .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW)
  );

  typedef struct packed {
    logic       rw, mw, jmp, jr, br;
    logic [1:0] rs, sa;
    logic       sb;
    logic [4:0] alu;
    logic [2:0] f3;
  } ctl_t;

  ctl_t        e_m, m_m, w_m;
  int          checks, failures;
  logic [31:0] ra, rb;
  int unsigned alu_of_f3 [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
  logic [6:0]  ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  // Instruction-level meaning of each RV32I/M encoding; illegal ones become bubbles.
  function automatic ctl_t decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  output logic ill, output logic [2:0] imm);
    ctl_t c;
    c = '0; ill = 1'b0; imm = 3'b000;
    c.f3 = f3;
    case (op)
      7'b0000011: begin c.rw = 1; c.sb = 1; c.rs = 2'b01; ill = (f3 != 3'd2); end
      7'b0100011: begin imm = 3'b001; c.mw = 1; c.sb = 1; ill = (f3 != 3'd2); end
      7'b0110011: begin
        c.rw = 1;
        if (f7 == 7'h00)                  c.alu = 5'(alu_of_f3[f3]);
        else if (f7 == 7'h20 && f3 == 0)  c.alu = 5'd1;
        else if (f7 == 7'h20 && f3 == 5)  c.alu = 5'd9;
        else if (f7 == 7'h01)             c.alu = 5'(16 + f3);
        else                              ill = 1'b1;
      end
      7'b0010011: begin
        c.rw = 1; c.sb = 1; c.alu = 5'(alu_of_f3[f3]);
        if (f3 == 1 && f7 != 7'h00) ill = 1'b1;
        if (f3 == 5 && f7 == 7'h20) c.alu = 5'd9;
        else if (f3 == 5 && f7 != 7'h00) ill = 1'b1;
      end
      7'b1100011: begin imm = 3'b010; c.br = 1; c.alu = 5'd1; ill = (f3 == 2 || f3 == 3); end
      7'b1101111: begin imm = 3'b100; c.jmp = 1; c.rw = 1; c.rs = 2'b10; end
      7'b1100111: begin c.jmp = 1; c.jr = 1; c.sb = 1; c.rw = 1; c.rs = 2'b10; ill = (f3 != 0); end
      7'b0110111: begin imm = 3'b011; c.rw = 1; c.rs = 2'b11; end
      7'b0010111: begin imm = 3'b011; c.sa = 2'b01; c.sb = 1; c.rw = 1; end
      default:    ill = 1'b1;
    endcase
    if (ill) c = '0;
    return c;
  endfunction

  function automatic logic taken(input logic [2:0] f3);
    case (f3)
      3'd0:    return ra == rb;
      3'd1:    return ra != rb;
      3'd4:    return $signed(ra) < $signed(rb);
      3'd5:    return $signed(ra) >= $signed(rb);
      3'd6:    return ra < rb;
      3'd7:    return ra >= rb;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] exp_pc();
    if (e_m.jr) return 2'b10;
    if (e_m.jmp || (e_m.br && taken(e_m.f3))) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Operands for the branch in E; the flags are those of rs1-rs2.
  task automatic set_ab(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    ra = a; rb = b; d = a - b;
    N_flag = d[31];
    Z_flag = (d == 32'd0);
    C_flag = (a >= b);
    V_flag = (a[31] ^ b[31]) & (d[31] ^ a[31]);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op; funct3 = f3; funct7 = f7;
  endtask

  task automatic check_all();
    logic       ill;
    logic [2:0] imm;
    ctl_t       unused_c;
    unused_c = decode(opcode, funct3, funct7, ill, imm);
    chk("ImmSrcD", 32'(ImmSrcD), 32'(imm));
    chk("IllegalD", 32'(IllegalD), 32'(ill));
    chk("ALUControlE", 32'(ALUControlE), 32'(e_m.alu));
    chk("ALUSrcAE", 32'(ALUSrcAE), 32'(e_m.sa));
    chk("ALUSrcBE", 32'(ALUSrcBE), 32'(e_m.sb));
    chk("PCSrcE", 32'(PCSrcE), 32'(exp_pc()));
    chk("ResultSrcE0", 32'(ResultSrcE0), 32'(e_m.rs[0]));
    chk("MemWriteM", 32'(MemWriteM), 32'(m_m.mw));
    chk("RegWriteM", 32'(RegWriteM), 32'(m_m.rw));
    chk("ResultSrcW", 32'(ResultSrcW), 32'(w_m.rs));
    chk("RegWriteW", 32'(RegWriteW), 32'(w_m.rw));
  endtask

  task automatic model_update();
    logic       ill;
    logic [2:0] imm;
    if (n_rst) begin
      e_m = '0; m_m = '0; w_m = '0;
    end else begin
      w_m = m_m;
      m_m = e_m;
      if (FlushE)       e_m = '0;
      else if (!StallE) e_m = decode(opcode, funct3, funct7, ill, imm);
    end
  endtask

  // Check the settled outputs, then advance both model and DUT by one clock.
  task automatic cycle();
    #1;
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    e_m = '0; m_m = '0; w_m = '0;
    n_rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    set_instr(7'b0110011, 3'd0, 7'h00);
    set_ab(32'd0, 32'd0);
    @(posedge clk); #1;
    cycle();
    chk("rst_alu", 32'(ALUControlE), 32'd0);
    chk("rst_regww", 32'(RegWriteW), 32'd0);

    n_rst = 1'b0;
    cycle();
    chk("add_alu", 32'(ALUControlE), 32'd0);
    set_instr(7'b0110011, 3'd0, 7'h20);
    cycle();
    chk("sub_alu", 32'(ALUControlE), 32'd1);
    chk("add_regwm", 32'(RegWriteM), 32'd1);
    set_instr(7'b0100011, 3'd2, 7'h00);
    cycle();
    chk("add_regww", 32'(RegWriteW), 32'd1);
    cycle();
    chk("sub_regww", 32'(RegWriteW), 32'd1);
    chk("sw_memwm", 32'(MemWriteM), 32'd1);

    set_instr(7'b1100011, 3'd0, 7'h00);
    cycle();
    set_ab(32'd5, 32'd5); #1;
    chk("beq_z1", 32'(PCSrcE), 32'd1);
    set_ab(32'd5, 32'd6); #1;
    chk("beq_z0", 32'(PCSrcE), 32'd0);
    set_instr(7'b1100011, 3'd6, 7'h00);
    cycle();
    set_ab(32'd1, 32'd2); #1;
    chk("bltu_c0", 32'(PCSrcE), 32'd1);
    set_instr(7'b1100011, 3'd7, 7'h00);
    cycle();
    set_ab(32'd1, 32'd2); #1;
    chk("bgeu_c0", 32'(PCSrcE), 32'd0);
    set_instr(7'b1100011, 3'd4, 7'h00);
    cycle();
    set_ab(32'hFFFF_FFFF, 32'd1); #1;
    chk("blt_neg", 32'(PCSrcE), 32'd1);

    set_instr(7'b1100111, 3'd0, 7'h00);
    cycle();
    chk("jalr_pc", 32'(PCSrcE), 32'd2);
    set_instr(7'b0100011, 3'd2, 7'h00);
    cycle();
    cycle();
    chk("jalr_rsw", 32'(ResultSrcW), 32'd2);
    chk("jalr_rww", 32'(RegWriteW), 32'd1);

    set_instr(7'b0000011, 3'd2, 7'h00);
    cycle();
    chk("lw_rs0", 32'(ResultSrcE0), 32'd1);
    set_instr(7'b0100011, 3'd2, 7'h00);
    StallE = 1'b1;
    cycle();
    chk("stall1_rs0", 32'(ResultSrcE0), 32'd1);
    cycle();
    chk("stall2_rs0", 32'(ResultSrcE0), 32'd1);
    FlushE = 1'b1;
    cycle();
    chk("flush_alusrcb", 32'(ALUSrcBE), 32'd0);
    chk("flush_rs0", 32'(ResultSrcE0), 32'd0);
    chk("flush_pc", 32'(PCSrcE), 32'd0);
    StallE = 1'b0; FlushE = 1'b0;
    cycle();
    chk("flush_memwm", 32'(MemWriteM), 32'd0);
    chk("flush_regwm", 32'(RegWriteM), 32'd0);

    set_instr(7'b1111111, 3'd0, 7'h00); #1;
    chk("ill_op_d", 32'(IllegalD), 32'd1);
    cycle();
    set_instr(7'b0110011, 3'd0, 7'h40); #1;
    chk("ill_f7_d", 32'(IllegalD), 32'd1);
    cycle();
    set_instr(7'b0100011, 3'd2, 7'h00);
    cycle();
    chk("ill_regwm", 32'(RegWriteM), 32'd0);
    chk("ill_memwm", 32'(MemWriteM), 32'd0);
    cycle();
    chk("ill_regww", 32'(RegWriteW), 32'd0);

    set_instr(7'b0110011, 3'd4, 7'h01); #1;
    chk("mext_legal", 32'(IllegalD), 32'd0);
    cycle();
    chk("mext_alu", 32'(ALUControlE), 32'h14);

    set_instr(7'b0110011, 3'd0, 7'h00);
    cycle();
    cycle();
    n_rst = 1'b1;
    cycle();
    chk("midrst_regwm", 32'(RegWriteM), 32'd0);
    chk("midrst_regww", 32'(RegWriteW), 32'd0);
    n_rst = 1'b0;
    cycle();

    for (int i = 0; i < 400; i++) begin
      logic [6:0] f7;
      case ($urandom % 4)
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      if ($urandom % 10 == 0) set_instr(7'($urandom), 3'($urandom), f7);
      else                    set_instr(ops[$urandom % 9], 3'($urandom), f7);
      StallE = ($urandom % 8 == 0);
      FlushE = ($urandom % 10 == 0);
      n_rst  = ($urandom % 50 == 0);
      if ($urandom % 4 == 0) begin
        logic [31:0] v;
        v = $urandom;
        set_ab(v, v);
      end else begin
        set_ab($urandom, $urandom);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
